// File: rtl/button_conditioner_pkg.sv
// Shared constants and helpers for the push-button conditioning stage.
// Default cycle counts are derived from the 25 MHz pixel clock.
package button_conditioner_pkg;

  localparam int CLK_FREQ_HZ         = 32'd25_000_000;
  localparam int DEBOUNCE_10MS       = CLK_FREQ_HZ / 32'd100;
  localparam int REPEAT_DELAY_500MS  = CLK_FREQ_HZ / 32'd2;
  localparam int REPEAT_PERIOD_100MS = CLK_FREQ_HZ / 32'd10;

  typedef enum logic [0:0] {
    REP_WAIT_DELAY  = 1'b0,
    REP_WAIT_PERIOD = 1'b1
  } rep_phase_e;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(max_val + 32'sd1);
    end
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: synchroniser chain, debounce counter with stable
// level L, and the auto-repeat pulse generator that runs while L is high.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic press_o
);

  localparam int DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = cnt_width(REP_MAX);
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

  localparam logic [DEB_W-1:0] DEB_ZERO    = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] DEB_ONE     = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ZERO    = {REP_W{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                   level_q, level_d;
  logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
  rep_phase_e             phase_q, phase_d;
  logic                   press_q, press_d;
  logic                   sample_s;

  assign sample_s = sync_q[SYNC_STAGES-1];

  // State register; reset returns the channel to the released state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{1'b0}};
      deb_cnt_q <= DEB_ZERO;
      level_q   <= 1'b0;
      rep_cnt_q <= REP_ZERO;
      phase_q   <= REP_WAIT_DELAY;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      rep_cnt_q <= rep_cnt_d;
      phase_q   <= phase_d;
      press_q   <= press_d;
    end
  end

  // Synchroniser shift and debounce: L flips after DEBOUNCE_CYCLES mismatches in a row.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pin_i};
    deb_cnt_d = deb_cnt_q;
    level_d   = level_q;
    if (sample_s == level_q) begin
      deb_cnt_d = DEB_ZERO;
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_cnt_d = DEB_ZERO;
      level_d   = ~level_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_ONE;
    end
  end

  // Press/repeat generator; keyed on level_d so a coincident release suppresses a pulse.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    phase_d   = phase_q;
    press_d   = 1'b0;
    if (!level_d) begin
      rep_cnt_d = REP_ZERO;
      phase_d   = REP_WAIT_DELAY;
    end else if (!level_q) begin
      rep_cnt_d = REP_ZERO;
      phase_d   = REP_WAIT_DELAY;
      press_d   = 1'b1;
    end else if (!REPEAT_EN) begin
      rep_cnt_d = rep_cnt_q;
    end else begin
      case (phase_q)
        REP_WAIT_DELAY: begin
          if (rep_cnt_q == DELAY_LAST) begin
            press_d   = 1'b1;
            rep_cnt_d = REP_ZERO;
            phase_d   = REP_WAIT_PERIOD;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_ONE;
          end
        end
        REP_WAIT_PERIOD: begin
          if (rep_cnt_q == PERIOD_LAST) begin
            press_d   = 1'b1;
            rep_cnt_d = REP_ZERO;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_ONE;
          end
        end
        default: begin
          rep_cnt_d = REP_ZERO;
          phase_d   = REP_WAIT_DELAY;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Board-side button conditioning for pong: optional pin inversion feeding two
// independent debounce/auto-repeat channels (up and down).
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS,
  parameter bit ACTIVE_HIGH     = 1'b1
) (
  input  logic CLK_25MHZ,
  input  logic RESET,
  input  logic BTN_UP_RAW,
  input  logic BTN_DOWN_RAW,
  output logic UP_LEVEL,
  output logic DOWN_LEVEL,
  output logic UP_PRESS,
  output logic DOWN_PRESS
);

  logic up_pin_s;
  logic down_pin_s;

  assign up_pin_s   = ACTIVE_HIGH ? BTN_UP_RAW   : ~BTN_UP_RAW;
  assign down_pin_s = ACTIVE_HIGH ? BTN_DOWN_RAW : ~BTN_DOWN_RAW;

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .clk    (CLK_25MHZ),
    .rst    (RESET),
    .pin_i  (up_pin_s),
    .level_o(UP_LEVEL),
    .press_o(UP_PRESS)
  );

  debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_down (
    .clk    (CLK_25MHZ),
    .rst    (RESET),
    .pin_i  (down_pin_s),
    .level_o(DOWN_LEVEL),
    .press_o(DOWN_PRESS)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: a timestamp/history model of the button rules checked
// every cycle, plus hand-computed pulse counts, intervals and latencies.
module tb_button_conditioner;

  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up_raw = 1'b0;
  logic dn_raw = 1'b0;
  logic up_level, dn_level, up_press, dn_press;

  int total = 0;
  int bad   = 0;
  int up_stamps[$];
  int dn_stamps[$];
  int cyc = 0;

  bit m_dly [2][SYNC];
  bit m_hist[2][DEB];
  bit m_lvl [2];
  int m_age [2];
  bit m_prs [2];

  button_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DELAY),
    .REPEAT_PERIOD(PERIOD), .ACTIVE_HIGH(1'b1)
  ) dut (
    .CLK_25MHZ(clk), .RESET(rst), .BTN_UP_RAW(up_raw), .BTN_DOWN_RAW(dn_raw),
    .UP_LEVEL(up_level), .DOWN_LEVEL(dn_level), .UP_PRESS(up_press), .DOWN_PRESS(dn_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < SYNC; k++) m_dly[c][k] = 1'b0;
      for (int k = 0; k < DEB; k++) m_hist[c][k] = 1'b0;
      m_lvl[c] = 1'b0;
      m_age[c] = 0;
      m_prs[c] = 1'b0;
    end
  endtask

  // L follows s once the last DEB samples all disagree with it; pulses are
  // placed by age since the accepted press.
  task automatic model_step(input int c, input bit raw);
    bit s;
    bit all_diff;
    bit nl;
    s = m_dly[c][SYNC-1];
    for (int k = SYNC - 1; k > 0; k--) m_dly[c][k] = m_dly[c][k-1];
    m_dly[c][0] = raw;
    for (int k = DEB - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
    m_hist[c][0] = s;
    all_diff = 1'b1;
    for (int k = 0; k < DEB; k++) if (m_hist[c][k] == m_lvl[c]) all_diff = 1'b0;
    nl = all_diff ? ~m_lvl[c] : m_lvl[c];
    if (nl && !m_lvl[c]) begin
      m_age[c] = 0;
      m_prs[c] = 1'b1;
    end else if (nl) begin
      m_age[c] = m_age[c] + 1;
      m_prs[c] = (DELAY > 0) && (m_age[c] >= DELAY) && ((m_age[c] - DELAY) % PERIOD == 0);
    end else begin
      m_age[c] = 0;
      m_prs[c] = 1'b0;
    end
    m_lvl[c] = nl;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else begin
        model_step(0, up_raw);
        model_step(1, dn_raw);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("up_level", int'(up_level), int'(m_lvl[0]));
      chk("down_level", int'(dn_level), int'(m_lvl[1]));
      chk("up_press", int'(up_press), int'(m_prs[0]));
      chk("down_press", int'(dn_press), int'(m_prs[1]));
      if (up_press) up_stamps.push_back(cyc);
      if (dn_press) dn_stamps.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_up_level(input bit want, output int lat);
    lat = 0;
    while (up_level !== want && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  function automatic int stamp_gap(input int i);
    if (up_stamps.size() > i) return up_stamps[i] - up_stamps[0];
    else return -1;
  endfunction

  initial begin
    int lat;
    int gw[4];
    int ugap[5];
    gw[0] = 1; gw[1] = 2; gw[2] = 3; gw[3] = 0;
    ugap[0] = 0; ugap[1] = 10; ugap[2] = 13; ugap[3] = 16; ugap[4] = 19;

    // Reset held with UP pressed, then released.
    rst = 1'b1; up_raw = 1'b1;
    tick(5);
    chk("reset_up_level", int'(up_level), 0);
    chk("reset_up_press", int'(up_press), 0);
    rst = 1'b0;
    wait_up_level(1'b1, lat);
    chk_rng("post_reset_accept_latency", lat, 5, 7);
    up_raw = 1'b0;
    tick(12);
    chk("post_reset_press_count", up_stamps.size(), 1);

    // Glitches of 1..3 cycles on DOWN are rejected.
    for (int i = 0; i < 3; i++) begin
      dn_raw = 1'b1; tick(gw[i]);
      dn_raw = 1'b0; tick(8);
    end
    chk("glitch_press_count", dn_stamps.size(), 0);
    chk("glitch_level", int'(dn_level), 0);
    // A pulse of exactly DEB cycles is accepted once.
    dn_raw = 1'b1; tick(4);
    dn_raw = 1'b0; tick(12);
    chk("min_width_press_count", dn_stamps.size(), 1);

    // Hold UP for 30 cycles: pulses at ages 0,10,13,...,28.
    up_stamps.delete();
    up_raw = 1'b1; tick(30);
    up_raw = 1'b0;
    wait_up_level(1'b0, lat);
    chk_rng("release_latency", lat, 5, 7);
    tick(6);
    chk("hold30_count", up_stamps.size(), 8);
    for (int i = 1; i < 4; i++) chk($sformatf("hold30_gap%0d", i), stamp_gap(i), ugap[i]);

    // Hold 31: release lands on the age-31 repeat, which must not fire.
    up_stamps.delete();
    up_raw = 1'b1; tick(31);
    up_raw = 1'b0; tick(12);
    chk("hold31_suppressed_count", up_stamps.size(), 8);

    // Chatter then a steady press: one accept.
    up_stamps.delete();
    for (int i = 0; i < 2; i++) begin
      up_raw = 1'b1; tick(2);
      up_raw = 1'b0; tick(2);
    end
    up_raw = 1'b1;
    wait_up_level(1'b1, lat);
    chk_rng("bounce_accept_latency", lat, 5, 7);
    tick(4);
    up_raw = 1'b0; tick(12);
    chk("bounce_press_count", up_stamps.size(), 1);

    // Both buttons together repeat in lockstep.
    up_stamps.delete(); dn_stamps.delete();
    up_raw = 1'b1; dn_raw = 1'b1; tick(20);
    up_raw = 1'b0; dn_raw = 1'b0; tick(12);
    chk("both_up_count", up_stamps.size(), 5);
    chk("both_down_count", dn_stamps.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("both_up_gap%0d", i), stamp_gap(i), ugap[i]);
    if (up_stamps.size() > 0 && dn_stamps.size() > 0) begin
      chk("both_same_cycle", dn_stamps[0], up_stamps[0]);
    end else begin
      chk("both_first_present", 0, 1);
    end

    // Reset at age 11 of a repeat sequence, button still held.
    up_stamps.delete();
    up_raw = 1'b1;
    lat = 0;
    while (up_stamps.size() < 2 && lat < 40) begin
      tick(1);
      lat++;
    end
    chk("midrep_second_pulse_seen", up_stamps.size(), 2);
    @(negedge clk); #2;
    chk("midrep_level_before_reset", int'(up_level), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_up_level", int'(up_level), 0);
    chk("async_reset_up_press", int'(up_press), 0);
    chk("async_reset_down_level", int'(dn_level), 0);
    chk("async_reset_down_press", int'(dn_press), 0);
    tick(3);
    up_stamps.delete();
    rst = 1'b0;
    lat = 0;
    while (up_stamps.size() == 0 && lat < 20) begin
      tick(1);
      lat++;
    end
    chk_rng("fresh_press_latency", lat, 5, 7);
    up_raw = 1'b0; tick(12);
    chk("fresh_press_count", up_stamps.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
